// File: rtl/parking_gate_scheduler_pkg.sv
// rtl/parking_gate_scheduler_pkg.sv - shared FSM encoding and slot constants for the gate scheduler
package parking_gate_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_REJECT = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam int SLOT_COUNT = 3;

    localparam logic [SLOT_COUNT-1:0] SLOT_NONE = 3'b000;
    localparam logic [SLOT_COUNT-1:0] SLOT_CAR1 = 3'b001;
    localparam logic [SLOT_COUNT-1:0] SLOT_CAR2 = 3'b010;
    localparam logic [SLOT_COUNT-1:0] SLOT_CAR3 = 3'b100;

    function automatic logic is_one_hot_slot(input logic [SLOT_COUNT-1:0] sel);
        return (sel == SLOT_CAR1) || (sel == SLOT_CAR2) || (sel == SLOT_CAR3);
    endfunction

endpackage

// File: rtl/parking_slot_picker.sv
// rtl/parking_slot_picker.sv - lowest-index free slot finder
// Ports:
//   occupancy  in   one bit per slot, 1 = occupied (bit0 = car1)
//   free_slot  out  one-hot lowest free slot, SLOT_NONE when the lot is full
//   none_free  out  1 when every slot is occupied
module parking_slot_picker
    import parking_gate_scheduler_pkg::*;
(
    input  logic [SLOT_COUNT-1:0] occupancy,
    output logic [SLOT_COUNT-1:0] free_slot,
    output logic                  none_free
);

    always_comb begin
        free_slot = SLOT_NONE;
        if (!occupancy[0]) begin
            free_slot = SLOT_CAR1;
        end else if (!occupancy[1]) begin
            free_slot = SLOT_CAR2;
        end else if (!occupancy[2]) begin
            free_slot = SLOT_CAR3;
        end
        none_free = &occupancy;
    end

endmodule

// File: rtl/parking_gate_scheduler.sv
// rtl/parking_gate_scheduler.sv - arbitrates entry/exit gate requests into one-hot slot commands
// Ports:
//   clk, reset                 clock and synchronous active-low reset
//   entry_req, exit_req        level requests from the gates
//   exit_sel                   one-hot slot that wants to leave
//   car1..3_state, full_flag   occupancy status from the datapath
//   car_enter, car_exit        single-cycle command pulses
//   car_sel                    one-hot slot of the current command, 000 otherwise
//   entry_ack/nack, exit_ack/nack  single-cycle responses
//   assigned_slot              slot granted to the last accepted entry
//   busy                       high whenever the FSM is not in IDLE
module parking_gate_scheduler
    import parking_gate_scheduler_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  entry_req,
    input  logic                  exit_req,
    input  logic [SLOT_COUNT-1:0] exit_sel,
    input  logic                  car1_state,
    input  logic                  car2_state,
    input  logic                  car3_state,
    input  logic                  full_flag,
    output logic                  car_enter,
    output logic                  car_exit,
    output logic [SLOT_COUNT-1:0] car_sel,
    output logic                  entry_ack,
    output logic                  entry_nack,
    output logic                  exit_ack,
    output logic                  exit_nack,
    output logic [SLOT_COUNT-1:0] assigned_slot,
    output logic                  busy
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t                state, state_next;
    logic                  prio_exit, prio_exit_next;
    logic [3:0]            settle_cnt, settle_cnt_next;

    logic [SLOT_COUNT-1:0] occupancy;
    logic [SLOT_COUNT-1:0] free_slot;
    logic                  none_free;
    logic                  entry_ok, exit_ok, serve_exit;

    logic                  car_enter_d, car_exit_d;
    logic [SLOT_COUNT-1:0] car_sel_d, assigned_slot_d;
    logic                  entry_ack_d, entry_nack_d, exit_ack_d, exit_nack_d;
    logic                  busy_d;

    assign occupancy = {car3_state, car2_state, car1_state};

    parking_slot_picker u_slot_picker (
        .occupancy (occupancy),
        .free_slot (free_slot),
        .none_free (none_free)
    );

    assign entry_ok = !full_flag && !none_free;
    assign exit_ok  = is_one_hot_slot(exit_sel) && ((exit_sel & occupancy) != SLOT_NONE);

    // The decision taken in IDLE is registered straight into the outputs, so the
    // pulse shows up in the ISSUE/REJECT cycle, one cycle after the request.
    always_comb begin
        state_next      = state;
        prio_exit_next  = prio_exit;
        settle_cnt_next = settle_cnt;
        serve_exit      = 1'b0;
        car_enter_d     = 1'b0;
        car_exit_d      = 1'b0;
        car_sel_d       = SLOT_NONE;
        entry_ack_d     = 1'b0;
        entry_nack_d    = 1'b0;
        exit_ack_d      = 1'b0;
        exit_nack_d     = 1'b0;
        assigned_slot_d = assigned_slot;

        case (state)
            ST_IDLE: begin
                if (entry_req || exit_req) begin
                    serve_exit = exit_req && (!entry_req || prio_exit);
                    // Priority only rotates when there was an actual contention.
                    if (entry_req && exit_req) begin
                        prio_exit_next = !prio_exit;
                    end
                    if (serve_exit) begin
                        if (exit_ok) begin
                            state_next = ST_ISSUE;
                            car_exit_d = 1'b1;
                            car_sel_d  = exit_sel;
                            exit_ack_d = 1'b1;
                        end else begin
                            state_next  = ST_REJECT;
                            exit_nack_d = 1'b1;
                        end
                    end else begin
                        if (entry_ok) begin
                            state_next      = ST_ISSUE;
                            car_enter_d     = 1'b1;
                            car_sel_d       = free_slot;
                            entry_ack_d     = 1'b1;
                            assigned_slot_d = free_slot;
                        end else begin
                            state_next   = ST_REJECT;
                            entry_nack_d = 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE, ST_REJECT: begin
                state_next      = ST_SETTLE;
                settle_cnt_next = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (settle_cnt <= 4'd1) begin
                    state_next      = ST_IDLE;
                    settle_cnt_next = 4'd0;
                end else begin
                    settle_cnt_next = settle_cnt - 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_d = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            prio_exit     <= 1'b1;
            settle_cnt    <= 4'd0;
            car_enter     <= 1'b0;
            car_exit      <= 1'b0;
            car_sel       <= SLOT_NONE;
            entry_ack     <= 1'b0;
            entry_nack    <= 1'b0;
            exit_ack      <= 1'b0;
            exit_nack     <= 1'b0;
            assigned_slot <= SLOT_NONE;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            prio_exit     <= prio_exit_next;
            settle_cnt    <= settle_cnt_next;
            car_enter     <= car_enter_d;
            car_exit      <= car_exit_d;
            car_sel       <= car_sel_d;
            entry_ack     <= entry_ack_d;
            entry_nack    <= entry_nack_d;
            exit_ack      <= exit_ack_d;
            exit_nack     <= exit_nack_d;
            assigned_slot <= assigned_slot_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// tb/tb_parking_gate_scheduler.sv - scoreboard bench for parking_gate_scheduler
module tb_parking_gate_scheduler;

    localparam int S = 2;

    typedef struct packed {
        logic       en;
        logic       ex;
        logic [2:0] sel;
        logic       eack;
        logic       enack;
        logic       xack;
        logic       xnack;
        logic [2:0] asg;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0, exit_req = 1'b0;
    logic [2:0] exit_sel = 3'b000;
    logic       car1_state = 1'b0, car2_state = 1'b0, car3_state = 1'b0;
    logic       full_flag = 1'b0;
    logic       car_enter, car_exit, entry_ack, entry_nack, exit_ack, exit_nack, busy;
    logic [2:0] car_sel, assigned_slot;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t sb[$];

    parking_gate_scheduler #(.SETTLE_CYCLES(S)) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_sel      (exit_sel),
        .car1_state    (car1_state),
        .car2_state    (car2_state),
        .car3_state    (car3_state),
        .full_flag     (full_flag),
        .car_enter     (car_enter),
        .car_exit      (car_exit),
        .car_sel       (car_sel),
        .entry_ack     (entry_ack),
        .entry_nack    (entry_nack),
        .exit_ack      (exit_ack),
        .exit_nack     (exit_nack),
        .assigned_slot (assigned_slot),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    wire pulse_any = car_enter | car_exit | entry_ack | entry_nack | exit_ack | exit_nack;
    wire ev_t obs_ev = '{car_enter, car_exit, car_sel, entry_ack, entry_nack,
                         exit_ack, exit_nack, assigned_slot};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        check("idle_timeout", 16'(busy), 16'd0);
    endtask

    // Number of clock edges until a pulse is visible (40 = timed out).
    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!pulse_any && n < 40);
    endtask

    task automatic push(input logic en, input logic ex, input logic [2:0] sel,
                        input logic ea, input logic ena, input logic xa,
                        input logic xna, input logic [2:0] asg);
        ev_t e;
        e = '{en, ex, sel, ea, ena, xa, xna, asg};
        sb.push_back(e);
    endtask

    task automatic set_lot(input logic [2:0] occ, input logic full);
        {car3_state, car2_state, car1_state} = occ;
        full_flag = full;
    endtask

    // Scoreboard monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        check("enter_exit_excl", 16'(car_enter & car_exit), 16'd0);
        check("entry_ack_nack_excl", 16'(entry_ack & entry_nack), 16'd0);
        check("exit_ack_nack_excl", 16'(exit_ack & exit_nack), 16'd0);
        if (pulse_any) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", 16'(obs_ev), 16'd0);
            end else begin
                check("sb_event", 16'(obs_ev), 16'(sb.pop_front()));
            end
        end
    end

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        check("rst_outputs", 16'(obs_ev), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);

        // Empty lot, entry on the first IDLE cycle after release
        reset = 1'b1;
        entry_req = 1'b1;
        push(1, 0, 3'b001, 1, 0, 0, 0, 3'b001);
        wait_pulse(n);
        entry_req = 1'b0;
        check("entry_latency", 16'(n), 16'd1);
        tick();
        check("busy_settle1", 16'(busy), 16'd1);
        check("enter_one_cycle", 16'(car_enter), 16'd0);
        tick();
        check("busy_settle2", 16'(busy), 16'd1);
        tick();
        check("busy_idle", 16'(busy), 16'd0);
        check("assigned_held", 16'(assigned_slot), 16'd1);

        // Contention right after reset: exit first, then entry into car3
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        set_lot(3'b011, 1'b0);
        exit_sel = 3'b010;
        entry_req = 1'b1;
        exit_req = 1'b1;
        push(0, 1, 3'b010, 0, 0, 1, 0, 3'b000);
        push(1, 0, 3'b100, 1, 0, 0, 0, 3'b100);
        wait_pulse(n);
        exit_req = 1'b0;
        check("exit_first_latency", 16'(n), 16'd1);
        wait_pulse(n);
        entry_req = 1'b0;
        check("entry_after_settle", 16'(n), 16'(S + 2));

        // Full lot entry is rejected
        wait_idle();
        set_lot(3'b111, 1'b1);
        entry_req = 1'b1;
        push(0, 0, 3'b000, 0, 1, 0, 0, 3'b100);
        wait_pulse(n);
        entry_req = 1'b0;
        check("nack_latency", 16'(n), 16'd1);
        check("nack_sel", 16'(car_sel), 16'd0);

        // Non-one-hot and unoccupied exit selections are rejected
        wait_idle();
        set_lot(3'b011, 1'b0);
        exit_sel = 3'b011;
        exit_req = 1'b1;
        push(0, 0, 3'b000, 0, 0, 0, 1, 3'b100);
        wait_pulse(n);
        exit_req = 1'b0;
        check("exit_bad_sel", 16'(n), 16'd1);
        wait_idle();
        exit_sel = 3'b100;
        exit_req = 1'b1;
        push(0, 0, 3'b000, 0, 0, 0, 1, 3'b100);
        wait_pulse(n);
        exit_req = 1'b0;
        check("exit_empty_slot", 16'(n), 16'd1);

        // Reset during SETTLE aborts cleanly, then a fresh entry is granted
        wait_idle();
        set_lot(3'b000, 1'b0);
        entry_req = 1'b1;
        push(1, 0, 3'b001, 1, 0, 0, 0, 3'b001);
        wait_pulse(n);
        entry_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("abort_outputs", 16'(obs_ev), 16'd0);
        check("abort_busy", 16'(busy), 16'd0);
        tick();
        reset = 1'b1;
        entry_req = 1'b1;
        push(1, 0, 3'b001, 1, 0, 0, 0, 3'b001);
        wait_pulse(n);
        entry_req = 1'b0;
        check("post_abort_latency", 16'(n), 16'd1);

        // Continuous contention on a half-full lot alternates exit/entry
        wait_idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_lot(3'b001, 1'b0);
        exit_sel = 3'b001;
        entry_req = 1'b1;
        exit_req = 1'b1;
        push(0, 1, 3'b001, 0, 0, 1, 0, 3'b000);
        push(1, 0, 3'b010, 1, 0, 0, 0, 3'b010);
        push(0, 1, 3'b001, 0, 0, 1, 0, 3'b010);
        push(1, 0, 3'b010, 1, 0, 0, 0, 3'b010);
        wait_pulse(n);
        check("alt_first", 16'(n), 16'd1);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(n);
            check("alt_gap", 16'(n), 16'(S + 2));
        end
        entry_req = 1'b0;
        exit_req = 1'b0;
        wait_idle();
        repeat (6) tick();
        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_gate_scheduler.md
PARKING_GATE_SCHEDULER -- requirements
Module: parking_gate_scheduler

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, 2, idle cycles after each issued command before the next grant (range 1..15).
REQ-002 SHALL have port: clk  in  1  single clock, rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port: entry_req  in  1  level request from entry gate.
REQ-005 SHALL have port: exit_req  in  1  level request from exit gate.
REQ-006 SHALL have port: exit_sel  in  3  one-hot slot leaving (001=car1, 010=car2, 100=car3).
REQ-007 SHALL have ports: car1_state, car2_state, car3_state  in  1 each  1 = slot occupied.
REQ-008 SHALL have port: full_flag  in  1  all slots occupied.
REQ-009 SHALL have ports: car_enter, car_exit  out  1 each  single-cycle command pulses to the entry/exit datapath.
REQ-010 SHALL have port: car_sel  out  3  one-hot slot for the current command, 000 otherwise.
REQ-011 SHALL have ports: entry_ack, entry_nack, exit_ack, exit_nack  out  1 each  single-cycle responses.
REQ-012 SHALL have port: assigned_slot  out  3  one-hot slot granted to the entering car, held until the next entry_ack.
REQ-013 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, REJECT, SETTLE; all outputs registered.
REQ-015 In IDLE with exactly one valid pending request, SHALL move to ISSUE; pulse + ack appear the cycle after the request is first seen (latency 1).
REQ-016 SHALL, when both requests are pending in IDLE, serve the side indicated by a priority bit and then toggle it; priority resets to exit.
REQ-017 SHALL choose the entry slot as the lowest-index free slot (car1 before car2 before car3), sampled in IDLE.
REQ-018 SHALL treat an entry as invalid when full_flag=1 or no slot is free; SHALL treat an exit as invalid when exit_sel is not one-hot or names an unoccupied slot.
REQ-019 An invalid request SHALL go to REJECT: one-cycle nack, no car_enter/car_exit, car_sel=000, then SETTLE.
REQ-020 In ISSUE (exactly one cycle) SHALL assert exactly one of car_enter/car_exit together with car_sel and the matching ack; assigned_slot updates in the same cycle on entry.
REQ-021 SHALL stay in SETTLE exactly SETTLE_CYCLES cycles with a down-counter, ignoring all requests, then return to IDLE.
REQ-022 SHALL never assert car_enter and car_exit in the same cycle, nor ack and nack for the same side.
REQ-023 Requesters SHALL drop req after ack/nack; a req still high on return to IDLE SHALL be served as a new request.
REQ-024 The non-served request SHALL remain pending and be evaluated on the next IDLE, with occupancy re-sampled then.
REQ-025 Input changes during ISSUE/REJECT/SETTLE SHALL have no effect on the current transaction.

Reset
REQ-026 With reset=0 at a rising edge, SHALL enter IDLE and clear all outputs, assigned_slot, and the settle counter, and set priority to exit.
REQ-027 Reset asserted mid-ISSUE or mid-SETTLE SHALL abort the transaction at that edge with no further pulse; no deferred ack/nack after reset release.
REQ-028 The first request SHALL be accepted in the first IDLE cycle after reset is released.

Structure
REQ-029 Shared package SHALL hold: FSM state encoding, SLOT_COUNT=3, one-hot slot constants, SLOT_NONE=000.
REQ-030 Free-slot selection SHALL be a sub-module parking_slot_picker (occupancy in, lowest free one-hot and none_free out); everything else stays in one module.

Verification
REQ-031 Empty lot, entry_req for 1 cycle -> next cycle car_enter=1, car_sel=001, entry_ack=1, assigned_slot=001; busy low after 1+2 cycles.
REQ-032 car1 and car2 occupied, entry_req and exit_req(exit_sel=010) together after reset -> exit served first (car_exit, car_sel=010); entry served after settle with car_sel=100.
REQ-033 full_flag=1, entry_req -> entry_nack one cycle, car_enter stays 0, car_sel=000.
REQ-034 exit_sel=011 or an unoccupied slot -> exit_nack, no car_exit pulse.
REQ-035 reset=0 during SETTLE following an entry -> all outputs 0 next edge, no further ack; after release, a new entry_req is granted with latency 1.
REQ-036 Both requests held high continuously on a half-full lot -> grants alternate exit/entry, each separated by exactly SETTLE_CYCLES idle cycles.
